// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for I-fill, D-fill and D write-through traffic.
// Grants one burst or write at a time and routes read-valid pulses back to the issuing side.
module mem_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int MEM_LAT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        i_stall,
    output logic        d_stall,
    output logic        wr_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } state_t;

    localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);
    localparam logic       SIDE_I    = 1'b0;
    localparam logic       SIDE_D    = 1'b1;

    state_t               state_r;
    state_t               state_next_s;
    logic [3:0]           issue_cnt_r;
    logic [3:0]           ret_cnt_r;
    logic [MEM_LAT-1:0]   pend_r;
    logic [MEM_LAT-1:0]   pend_next_s;
    logic                 last_fill_r;
    logic                 fill_s;
    logic                 x_req_s;
    logic [15:0]          x_addr_s;
    logic                 issue_s;
    logic                 routed_s;
    logic                 burst_done_s;
    logic                 drained_s;
    logic                 fill_exit_s;

    // Select the request and address of the side currently owning the memory
    always_comb begin
        fill_s   = 1'b0;
        x_req_s  = 1'b0;
        x_addr_s = 16'h0000;
        case (state_r)
            FILL_I: begin
                fill_s   = 1'b1;
                x_req_s  = i_req;
                x_addr_s = i_addr;
            end
            FILL_D: begin
                fill_s   = 1'b1;
                x_req_s  = d_req;
                x_addr_s = d_addr;
            end
            default: begin
                fill_s   = 1'b0;
                x_req_s  = 1'b0;
                x_addr_s = 16'h0000;
            end
        endcase
    end

    // The pending pipe mirrors the memory latency; its top bit marks the read returning now
    assign issue_s      = fill_s & x_req_s & (issue_cnt_r < BURST_CNT);
    assign routed_s     = fill_s & mem_data_valid & pend_r[MEM_LAT-1];
    assign pend_next_s  = {pend_r[MEM_LAT-2:0], issue_s};
    assign burst_done_s = routed_s & (ret_cnt_r == (BURST_CNT - 4'd1));
    assign drained_s    = (pend_next_s == '0);
    // A fully issued burst whose reads all drained without data is released too, so a lost return cannot hang the port
    assign fill_exit_s  = fill_s & (burst_done_s |
                          (drained_s & (~x_req_s | (issue_cnt_r == BURST_CNT))));

    // Grant decision and fill termination
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_req) begin
                    state_next_s = WRITE;
                end else if (i_req && d_req) begin
                    state_next_s = (last_fill_r == SIDE_I) ? FILL_D : FILL_I;
                end else if (i_req) begin
                    state_next_s = FILL_I;
                end else if (d_req) begin
                    state_next_s = FILL_D;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                state_next_s = IDLE;
            end
            FILL_I, FILL_D: begin
                if (fill_exit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Memory-side drive, valid routing and stall flags
    always_comb begin
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;
        wr_ack       = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        case (state_r)
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = wr_addr;
                mem_data_in = wr_data;
                wr_ack      = 1'b1;
            end
            FILL_I: begin
                mem_enable   = issue_s;
                mem_addr     = x_addr_s;
                i_data_valid = routed_s;
            end
            FILL_D: begin
                mem_enable   = issue_s;
                mem_addr     = x_addr_s;
                d_data_valid = routed_s;
            end
            default: begin
                mem_enable   = 1'b0;
                mem_addr     = 16'h0000;
            end
        endcase
        // Stalls are forced low while reset is held so every output is quiet during reset
        i_stall = rst_n & i_req & (state_r != FILL_I);
        d_stall = rst_n & ((d_req & (state_r != FILL_D)) | (wr_req & (state_r != WRITE)));
    end

    // State, burst counters, pending pipe and fairness bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            issue_cnt_r <= 4'd0;
            ret_cnt_r   <= 4'd0;
            pend_r      <= '0;
            last_fill_r <= SIDE_I;
        end else begin
            state_r <= state_next_s;
            if (fill_exit_s) begin
                issue_cnt_r <= 4'd0;
                ret_cnt_r   <= 4'd0;
                pend_r      <= '0;
                last_fill_r <= (state_r == FILL_D) ? SIDE_D : SIDE_I;
            end else if (fill_s) begin
                if (issue_s) begin
                    issue_cnt_r <= issue_cnt_r + 4'd1;
                end else begin
                    issue_cnt_r <= issue_cnt_r;
                end
                if (routed_s && (ret_cnt_r < BURST_CNT)) begin
                    ret_cnt_r <= ret_cnt_r + 4'd1;
                end else begin
                    ret_cnt_r <= ret_cnt_r;
                end
                pend_r <= pend_next_s;
            end else begin
                issue_cnt_r <= 4'd0;
                ret_cnt_r   <= 4'd0;
                pend_r      <= '0;
                last_fill_r <= last_fill_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected issues/valids, a negedge monitor
// pops and compares them, and a small memory model returns read valids MEM_LAT cycles later.
module tb_mem_arbiter;

    localparam int          MEM_LAT = 4;
    localparam logic [15:0] I_BASE  = 16'h1000;
    localparam logic [15:0] D_BASE  = 16'h2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, wr_req = 1'b0;
    logic [15:0] i_addr = I_BASE, d_addr = D_BASE;
    logic [15:0] wr_addr = 16'h0000, wr_data = 16'h0000;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_enable, mem_wr, i_data_valid, d_data_valid, i_stall, d_stall, wr_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.BURST_LEN(8), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_in(mem_data_in), .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .i_stall(i_stall), .d_stall(d_stall), .wr_ack(wr_ack)
    );

    typedef struct packed { logic [31:0] c; logic [15:0] a; logic wr; logic [15:0] d; } iss_t;
    typedef struct packed { logic [31:0] c; logic i; logic d; } val_t;

    iss_t iss_q[$];
    val_t val_q[$];
    int   ret_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic spur = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_rd(input int c, input logic [15:0] a);
        iss_q.push_back('{c: 32'(c), a: a, wr: 1'b0, d: 16'h0000});
    endtask

    task automatic push_val(input int c, input logic side_d);
        val_q.push_back('{c: 32'(c), i: ~side_d, d: side_d});
    endtask

    // Full burst granted at cycle t: issues t+1..t+8, returns t+5..t+12
    task automatic exp_burst(input int t, input logic side_d);
        for (int k = 1; k <= 8; k++) begin
            push_rd(t + k, (side_d ? D_BASE : I_BASE) + 16'(t + k));
            push_val(t + k + MEM_LAT, side_d);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((iss_q.size() + val_q.size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(name, 96'(iss_q.size() + val_q.size()), 96'd0);
        repeat (2) tick();
    endtask

    function automatic logic [95:0] all_outs();
        return 96'({mem_addr, mem_enable, mem_wr, mem_data_in, i_data_valid,
                    d_data_valid, i_stall, d_stall, wr_ack});
    endfunction

    initial begin
        int t, t2;
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(posedge clk);
                #1;
                i_addr = I_BASE + 16'(cyc);
                d_addr = D_BASE + 16'(cyc);
            end
            forever begin : memory_model
                logic mv;
                @(posedge clk);
                #2;
                mv = 1'b0;
                while (ret_q.size() > 0 && ret_q[0] < cyc) void'(ret_q.pop_front());
                if (ret_q.size() > 0 && ret_q[0] == cyc) begin
                    void'(ret_q.pop_front());
                    mv = 1'b1;
                end
                mem_data_valid = mv | spur;
            end
            forever begin : monitor
                iss_t e;
                val_t v;
                @(negedge clk);
                if (rst_n) begin
                    if (mem_enable || wr_ack) begin
                        if (mem_enable && !mem_wr) ret_q.push_back(cyc + MEM_LAT);
                        if (iss_q.size() == 0) begin
                            chk("issue_unexpected", 96'({32'(cyc), mem_addr}), 96'd0);
                        end else begin
                            e = iss_q.pop_front();
                            chk("issue", 96'({32'(cyc), mem_enable, mem_addr, mem_wr, wr_ack,
                                              mem_wr ? mem_data_in : 16'h0000}),
                                         96'({e.c, 1'b1, e.a, e.wr, e.wr, e.d}));
                        end
                    end
                    if (i_data_valid || d_data_valid) begin
                        if (val_q.size() == 0) begin
                            chk("valid_unexpected", 96'({32'(cyc), i_data_valid, d_data_valid}), 96'd0);
                        end else begin
                            v = val_q.pop_front();
                            chk("valid", 96'({32'(cyc), i_data_valid, d_data_valid}),
                                         96'({v.c, v.i, v.d}));
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: bench did not finish in time");
                $fatal(1, "timeout");
            end
        join_none

        // Reset with every request and a data-valid asserted: outputs must stay 0
        i_req = 1'b1; d_req = 1'b1; wr_req = 1'b1; spur = 1'b1;
        wr_addr = 16'h1234; wr_data = 16'h5678;
        repeat (2) tick();
        #3; chk("reset_outputs", all_outs(), 96'd0);
        tick();
        i_req = 1'b0; d_req = 1'b0; wr_req = 1'b0; spur = 1'b0; rst_n = 1'b1;
        repeat (3) tick();

        // Single I fill, spurious valid in IDLE and before the first return
        t = cyc;
        i_req = 1'b1; spur = 1'b1;
        exp_burst(t, 1'b0);
        #3; chk("spur_idle", 96'({i_data_valid, d_data_valid}), 96'd0);
        goto(t + 1); spur = 1'b0;
        #3; chk("a_i_stall_granted", 96'(i_stall), 96'd0);
        for (int k = 2; k <= 4; k++) begin
            goto(t + k); spur = 1'b1;
            #3; chk("spur_fill", 96'({i_data_valid, d_data_valid}), 96'd0);
        end
        goto(t + 5); spur = 1'b0;
        goto(t + 13); i_req = 1'b0;
        #3; chk("a_idle_no_issue", 96'(mem_enable), 96'd0);
        drain("drain_single_fill");

        // Simultaneous fills after reset: D first, then I after one IDLE cycle
        rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1; tick();
        t = cyc;
        i_req = 1'b1; d_req = 1'b1;
        exp_burst(t, 1'b1);
        exp_burst(t + 13, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            goto(t + k);
            #3;
            chk("b_i_stall", 96'(i_stall), 96'd1);
            chk("b_d_stall", 96'(d_stall), 96'd0);
        end
        goto(t + 13); d_req = 1'b0;
        goto(t + 14);
        #3; chk("b_i_granted", 96'(i_stall), 96'd0);
        goto(t + 26); i_req = 1'b0;
        drain("drain_simultaneous");

        // Write arriving during a D fill waits for the fill to end
        t = cyc;
        d_req = 1'b1;
        exp_burst(t, 1'b1);
        iss_q.push_back('{c: 32'(t + 14), a: 16'h0040, wr: 1'b1, d: 16'hBEEF});
        goto(t + 1);
        #3; chk("c_d_stall_fill", 96'(d_stall), 96'd0);
        goto(t + 3); wr_req = 1'b1; wr_addr = 16'h0040; wr_data = 16'hBEEF;
        for (int k = 3; k <= 13; k++) begin
            goto(t + k);
            if (k == 13) d_req = 1'b0;
            #3; chk("c_d_stall_wr_wait", 96'(d_stall), 96'd1);
        end
        goto(t + 14);
        #3; chk("c_d_stall_write", 96'(d_stall), 96'd0);
        goto(t + 15); wr_req = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000;
        drain("drain_write");

        // I fill aborted after 3 issues; a D request at t+8 exposes the IDLE cycle
        t = cyc;
        i_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push_rd(t + k, I_BASE + 16'(t + k));
            push_val(t + k + MEM_LAT, 1'b0);
        end
        goto(t + 4); i_req = 1'b0;
        #3; chk("d_no_issue_after_abort", 96'(mem_enable), 96'd0);
        goto(t + 8); d_req = 1'b1;
        exp_burst(t + 8, 1'b1);
        goto(t + 21); d_req = 1'b0;
        drain("drain_abort");

        // Reset in cycle 6 of an I fill; late returns must be dropped
        t = cyc;
        i_req = 1'b1;
        for (int k = 1; k <= 5; k++) push_rd(t + k, I_BASE + 16'(t + k));
        push_val(t + 5, 1'b0);
        goto(t + 6);
        #2; rst_n = 1'b0;
        #1; chk("reset_mid_outputs", all_outs(), 96'd0);
        goto(t + 7); i_req = 1'b0; rst_n = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            goto(t + k);
            #3; chk("late_valid_dropped", 96'({i_data_valid, d_data_valid}), 96'd0);
        end
        goto(t + 10);
        t2 = t + 10;
        i_req = 1'b1;
        exp_burst(t2, 1'b0);
        goto(t2 + 13); i_req = 1'b0;
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
